// File: rtl/link_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack byte link among NREQ masters.
// Relays the slave handshake to the granted master and aborts on slave timeout.
module link_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15,
  parameter int CNTW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      m_req,
  input  logic [NREQ*DW-1:0]   m_data,
  output logic [NREQ-1:0]      m_ack,
  output logic [NREQ-1:0]      grant,
  output logic                 s_req,
  output logic [DW-1:0]        s_data,
  input  logic                 s_ack,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [CNTW-1:0]      xfer_count
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, REQ, ACKD, REL, DRAIN} state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   cand;
  logic            found;
  logic [DW-1:0]   win_data;
  logic [TW-1:0]   timer;
  logic            timed_out;
  logic            owner_req;

  // Search starts just after the last served master; first requester wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    winner = last;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!found && m_req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == winner) win_data = m_data[i*DW +: DW];
    end
  end

  assign owner_req = |(m_req & grant);
  assign timed_out = (TIMEOUT > 0) && (32'(timer) == 32'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      m_ack       <= '0;
      grant       <= '0;
      s_req       <= 1'b0;
      s_data      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      xfer_count  <= '0;
      last        <= IW'(NREQ - 1);
      owner       <= '0;
      timer       <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant  <= NREQ'(1) << winner;
            owner  <= winner;
            s_data <= win_data;
            s_req  <= 1'b1;
            busy   <= 1'b1;
            timer  <= '0;
            state  <= REQ;
          end
        end
        REQ: begin
          if (s_ack) begin
            m_ack <= grant;
            state <= ACKD;
          end else if (timed_out) begin
            s_req       <= 1'b0;
            timeout_err <= 1'b1;
            state       <= DRAIN;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ACKD: begin
          // A master that dropped m_req early leaves here on the first cycle.
          if (!owner_req) begin
            s_req <= 1'b0;
            state <= REL;
          end
        end
        REL: begin
          if (!s_ack) begin
            m_ack      <= '0;
            grant      <= '0;
            busy       <= 1'b0;
            xfer_count <= xfer_count + CNTW'(1);
            last       <= owner;
            state      <= IDLE;
          end
        end
        DRAIN: begin
          // Aborted master goes to the back of the rotation but may retry.
          if (!s_ack) begin
            grant <= '0;
            busy  <= 1'b0;
            last  <= owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
